// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Host register bridge over a UART pair. Generates baudclk16,
//               parses 'W' addr data / 'R' addr commands and returns a
//               one-byte response ('K', read data or '?').
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int BAUD_DIV      = 27,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic       clk,
    input  logic       reset,
    output logic       baudclk16,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_read,
    output logic [7:0] tx_data,
    output logic       tx_write,
    input  logic       tx_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic [7:0] err_count
);

    localparam int c_baud_w = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int c_tick_w = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TIMEOUT_TICKS - 1);
    localparam logic [7:0] c_op_write  = 8'h57;
    localparam logic [7:0] c_op_read   = 8'h52;
    localparam logic [7:0] c_resp_ok   = 8'h4B;
    localparam logic [7:0] c_resp_bad  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_ADDR  = 3'd1,
        S_GET_DATA  = 3'd2,
        S_DO_WRITE  = 3'd3,
        S_DO_READ   = 3'd4,
        S_RD_WAIT   = 3'd5,
        S_SEND      = 3'd6,
        S_SEND_WAIT = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_baud_w-1:0] r_baud_cnt;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [c_tick_w-1:0] w_tick_cnt_nxt;
    logic                r_op_read;
    logic                w_op_read_nxt;
    logic [7:0]          r_tx_byte;
    logic [7:0]          w_tx_byte_nxt;
    logic [7:0]          r_tx_data;
    logic [7:0]          w_tx_data_nxt;
    logic [7:0]          r_reg_addr;
    logic [7:0]          w_reg_addr_nxt;
    logic [7:0]          r_reg_wdata;
    logic [7:0]          w_reg_wdata_nxt;
    logic                r_rx_read;
    logic                w_rx_read_nxt;
    logic                r_tx_write;
    logic                w_tx_write_nxt;
    logic                r_reg_we;
    logic                w_reg_we_nxt;
    logic                r_reg_re;
    logic                w_reg_re_nxt;
    logic [7:0]          r_err_count;
    logic                w_err_inc;
    logic                w_baud_tick;
    logic                w_take;
    logic                w_expire;

    assign w_baud_tick = (r_baud_cnt == c_baud_last);
    // uart_rx still shows the consumed byte during the rx_read cycle
    assign w_take      = rx_ready && !r_rx_read;
    assign w_expire    = w_baud_tick && (r_tick_cnt == c_tick_last);

    assign baudclk16 = w_baud_tick;
    assign rx_read   = r_rx_read;
    assign tx_data   = r_tx_data;
    assign tx_write  = r_tx_write;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_we    = r_reg_we;
    assign reg_re    = r_reg_re;
    assign err_count = r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud_cnt <= '0;
        end else if (w_baud_tick) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_op_read   <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_tx_data   <= 8'h00;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_rx_read   <= 1'b0;
            r_tx_write  <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_err_count <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_op_read   <= w_op_read_nxt;
            r_tx_byte   <= w_tx_byte_nxt;
            r_tx_data   <= w_tx_data_nxt;
            r_reg_addr  <= w_reg_addr_nxt;
            r_reg_wdata <= w_reg_wdata_nxt;
            r_rx_read   <= w_rx_read_nxt;
            r_tx_write  <= w_tx_write_nxt;
            r_reg_we    <= w_reg_we_nxt;
            r_reg_re    <= w_reg_re_nxt;
            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_op_read_nxt   = r_op_read;
        w_tx_byte_nxt   = r_tx_byte;
        w_tx_data_nxt   = r_tx_data;
        w_reg_addr_nxt  = r_reg_addr;
        w_reg_wdata_nxt = r_reg_wdata;
        w_rx_read_nxt   = 1'b0;
        w_tx_write_nxt  = 1'b0;
        w_reg_we_nxt    = 1'b0;
        w_reg_re_nxt    = 1'b0;
        w_err_inc       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_rx_read_nxt  = 1'b1;
                    w_tick_cnt_nxt = '0;
                    if (rx_data == c_op_write) begin
                        w_op_read_nxt = 1'b0;
                        w_state_nxt   = S_GET_ADDR;
                    end else if (rx_data == c_op_read) begin
                        w_op_read_nxt = 1'b1;
                        w_state_nxt   = S_GET_ADDR;
                    end else begin
                        w_tx_byte_nxt = c_resp_bad;
                        w_err_inc     = 1'b1;
                        w_state_nxt   = S_SEND;
                    end
                end
            end

            S_GET_ADDR: begin
                // A byte on the expiry cycle still counts
                if (w_take) begin
                    w_rx_read_nxt  = 1'b1;
                    w_tick_cnt_nxt = '0;
                    w_reg_addr_nxt = rx_data;
                    w_reg_re_nxt   = r_op_read;
                    w_state_nxt    = r_op_read ? S_DO_READ : S_GET_DATA;
                end else if (w_expire) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_baud_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end

            S_GET_DATA: begin
                if (w_take) begin
                    w_rx_read_nxt   = 1'b1;
                    w_tick_cnt_nxt  = '0;
                    w_reg_wdata_nxt = rx_data;
                    w_reg_we_nxt    = 1'b1;
                    w_state_nxt     = S_DO_WRITE;
                end else if (w_expire) begin
                    w_err_inc   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_baud_tick) begin
                    w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                end
            end

            S_DO_WRITE: begin
                w_tx_byte_nxt = c_resp_ok;
                w_state_nxt   = S_SEND;
            end

            S_DO_READ: begin
                w_state_nxt = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                w_tx_byte_nxt = reg_rdata;
                w_state_nxt   = S_SEND;
            end

            S_SEND: begin
                if (tx_ready) begin
                    w_tx_write_nxt = 1'b1;
                    w_tx_data_nxt  = r_tx_byte;
                    w_state_nxt    = S_SEND_WAIT;
                end
            end

            S_SEND_WAIT: begin
                // tx_ready only drops after the write cycle, so skip that cycle
                if (!r_tx_write && tx_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
